cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Coprocessor-0 responder for the privileged instructions the ID stage flags (mtc0, mfc0, eret).
- Holds the architectural CP0 state: BadVAddr, Count, Compare, Status, Cause and EPC.
- Commits exceptions and eret, and generates the interrupt request and flush target for the pipeline.
- Instantiated once in the datapath. Writes come from the mtc0 commit point; exception and eret events come from the MEM-stage exception unit.

Parameters:
- EXC_VECTOR, 32'hBFC00380: target PC on exception entry.
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles; legal values 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- we_i  in  1  mtc0 commit
- waddr_i  in  5  mtc0 rd field
- wdata_i  in  32  mtc0 data
- raddr_i  in  5  mfc0 rd field
- rdata_o  out  32  mfc0 read data
- int_i  in  6  hardware interrupt lines (level)
- exc_valid_i  in  1  exception committed this cycle
- exc_code_i  in  5  ExcCode
- exc_pc_i  in  32  PC of faulting instruction
- exc_bd_i  in  1  faulting instruction is in a delay slot
- exc_badvaddr_i  in  32  faulting address
- eret_i  in  1  eret committed this cycle
- status_o  out  32  Status register
- cause_o  out  32  Cause register
- epc_o  out  32  EPC register
- int_pending_o  out  1  interrupt request to the exception unit
- flush_o  out  1  pipeline flush, asserted in the cycle after an exception or eret
- flush_pc_o  out  32  redirect PC, valid while flush_o=1

Behaviour:
- Register map (rd): 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other address reads 0 and ignores writes.
- Reset values (asynchronous): Status=32'h0040_0000 (BEV=1), all other registers 0. flush_o=0, flush_pc_o=0, int_pending_o=0, internal divider and TI cleared.
- Read: rdata_o is combinational from the current registers. A write in the same cycle becomes visible on the next cycle; there is no bypass.
- Status write mask: IM[15:8], EXL[1], IE[0]. BEV[22] is hard 1; all other bits read 0.
- Cause write mask: IP[9:8] (software interrupts) only.
- Cause hardware fields, updated every cycle:
  - IP[14:10] = int_i[4:0]
  - IP[15] = int_i[5] | TI
  - TI is Cause[30]
- BadVAddr is read-only to mtc0.
- Count:
  - Free-running; increments when the divider wraps; wraps at 2^32 to 0.
  - An mtc0 to Count loads wdata_i and resets the divider, and takes priority over the increment.
- Timer interrupt:
  - TI sets on the cycle Count==Compare and stays set until the next mtc0 to Compare.
  - An mtc0 to Compare clears TI; the clear wins over a same-cycle match.
- Interrupt request: int_pending_o = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP). Registered, so it appears one cycle after the condition.
- Exception commit (exc_valid_i=1), priority over eret and we_i:
  - If EXL=0: EPC = exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD = exc_bd_i.
  - If EXL=1: EPC and BD are unchanged.
  - In both cases: EXL=1 and Cause.ExcCode = exc_code_i.
  - If exc_code_i is 4 (AdEL) or 5 (AdES): BadVAddr = exc_badvaddr_i.
  - Next cycle: flush_o=1 and flush_pc_o=EXC_VECTOR.
- eret commit (eret_i=1, no exception): EXL=0. Next cycle: flush_o=1 and flush_pc_o = EPC value before this cycle's updates. Any same-cycle we_i is dropped.
- Same-cycle exc_valid_i and eret_i: the exception wins and eret is ignored.
- flush_o is a single-cycle pulse, except that back-to-back events produce back-to-back pulses.
- rst asserted mid-operation returns all state to reset values immediately, including clearing a pending flush.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: Count, Compare, the divider and TI are implemented as described above.
- Undefined: Count and Compare read 0 and ignore writes, TI is constant 0, and IP[15]=int_i[5]. No timer flops are synthesised.

Decomposition:
- Package cp0_pkg holds:
  - register address constants (CP0_BADVADDR..CP0_EPC)
  - ExcCode constants (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12)
  - Status/Cause bit-position constants
  - the Status reset value and write masks
- One natural sub-module, cp0_timer: divider, Count, Compare, TI. It is instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset: release rst, read rd=12 and rd=13 -> 32'h0040_0000 and 0; flush_o=0.
- Masked write: mtc0 rd=12 with 32'hFFFF_FFFF, then mfc0 rd=12 -> 32'h0040_FF03. mtc0 rd=8 with 32'h1234 -> BadVAddr stays 0.
- Delay-slot exception: exc_valid_i with code 4, pc 32'hBFC0_0104, bd=1, badvaddr 32'h0000_0003 ->
  - EPC=32'hBFC0_0100, Cause=32'h8000_0010, BadVAddr=32'h3, EXL=1
  - next cycle flush_o=1 with flush_pc_o=32'hBFC0_0380
  - a second exception while EXL=1 leaves EPC unchanged.
- eret: with EPC=32'hBFC0_0200 and EXL=1, pulse eret_i -> EXL=0 and next cycle flush_pc_o=32'hBFC0_0200. Same-cycle exc_valid_i+eret_i -> flush_pc_o=EXC_VECTOR.
- Timer (CP0_TIMER_EN, COUNT_DIV=2): Compare=10, Count=0, Status=32'h0000_8001 ->
  - TI sets 20 cycles later
  - int_pending_o=1 one cycle after TI
  - mtc0 Compare clears TI and int_pending_o.
- Hardware interrupt: Status=32'h0000_0401, int_i=6'b000001 -> int_pending_o=1 after one cycle. Same with EXL=1 -> int_pending_o=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register addresses, ExcCodes, Status/Cause bit positions and masks.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int unsigned ST_IE   = 0;
    localparam int unsigned ST_EXL  = 1;
    localparam int unsigned ST_BEV  = 22;
    localparam int unsigned CA_BD   = 31;
    localparam int unsigned CA_TI   = 30;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled free-running Count and sticky timer interrupt TI.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic [1:0] DIV_LAST = 2'(COUNT_DIV - 1);

    logic [1:0] div_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div_q <= '0;
            end else if (div_q == DIV_LAST) begin
                div_q <= '0;
                count <= count + 32'd1;
            end else begin
                div_q <= div_q + 2'd1;
            end
            if (compare_we) begin
                compare <= wdata;
            end
            // Writing Compare acknowledges the timer, even against a same-cycle match.
            if (compare_we) begin
                ti <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: mtc0/mfc0 access, exception/eret commit, interrupt request and flush.
// Timer (Count/Compare/TI) present only when CP0_TIMER_EN is defined.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_bd_i,
    input  logic [31:0] exc_badvaddr_i,
    input  logic        eret_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_pending_o,
    output logic        flush_o,
    output logic [31:0] flush_pc_o
);

    if (COUNT_DIV < 1 || COUNT_DIV > 4) begin : g_bad_div
        $error("COUNT_DIV must be in 1..4");
    end

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        wr_en;
    logic [5:0]  hw_ip;
    logic        int_cond;

    // Exceptions and eret both swallow a same-cycle mtc0.
    assign wr_en = we_i & ~exc_valid_i & ~eret_i;

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_en && (waddr_i == CP0_COUNT)),
        .compare_we (wr_en && (waddr_i == CP0_COMPARE)),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    assign hw_ip    = {int_i[5] | ti, int_i[4:0]};
    assign status_o = status_q;
    assign cause_o  = cause_q | {1'b0, ti, 14'b0, hw_ip, 10'b0};
    assign epc_o    = epc_q;
    assign int_cond = status_q[ST_IE] & ~status_q[ST_EXL] & (|(status_q[15:8] & cause_o[15:8]));

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badvaddr_q;
            CP0_COUNT:    rdata_o = count;
            CP0_COMPARE:  rdata_o = compare;
            CP0_STATUS:   rdata_o = status_o;
            CP0_CAUSE:    rdata_o = cause_o;
            CP0_EPC:      rdata_o = epc_q;
            default:      rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q      <= STATUS_RESET;
            cause_q       <= '0;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            int_pending_o <= 1'b0;
            flush_o       <= 1'b0;
            flush_pc_o    <= '0;
        end else begin
            int_pending_o <= int_cond;
            flush_o       <= exc_valid_i | eret_i;
            if (exc_valid_i) begin
                flush_pc_o <= EXC_VECTOR;
                // Nested exceptions keep the original return point.
                if (!status_q[ST_EXL]) begin
                    epc_q          <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                    cause_q[CA_BD] <= exc_bd_i;
                end
                status_q[ST_EXL] <= 1'b1;
                cause_q[6:2]     <= exc_code_i;
                if (is_addr_exc(exc_code_i)) begin
                    badvaddr_q <= exc_badvaddr_i;
                end
            end else if (eret_i) begin
                flush_pc_o       <= epc_q;
                status_q[ST_EXL] <= 1'b0;
            end else if (wr_en) begin
                case (waddr_i)
                    CP0_STATUS: status_q <= (wdata_i & STATUS_WMASK) | STATUS_RESET;
                    CP0_CAUSE:  cause_q  <= (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
                    CP0_EPC:    epc_q    <= wdata_i;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: directed scenarios plus randomized traffic vs a reference model.
module tb_cp0_regfile;

    localparam logic [31:0] Vec      = 32'hBFC0_0380;
    localparam int          CountDiv = 2;
`ifdef CP0_TIMER_EN
    localparam bit TimerEn = 1'b1;
`else
    localparam bit TimerEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [31:0] rdata_o;
    logic [5:0]  int_i = '0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = '0;
    logic [31:0] exc_pc_i = '0;
    logic        exc_bd_i = 1'b0;
    logic [31:0] exc_badvaddr_i = '0;
    logic        eret_i = 1'b0;
    logic [31:0] status_o, cause_o, epc_o, flush_pc_o;
    logic        int_pending_o, flush_o;

    cp0_regfile #(
        .EXC_VECTOR (Vec),
        .COUNT_DIV  (CountDiv)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .int_i          (int_i),
        .exc_valid_i    (exc_valid_i),
        .exc_code_i     (exc_code_i),
        .exc_pc_i       (exc_pc_i),
        .exc_bd_i       (exc_bd_i),
        .exc_badvaddr_i (exc_badvaddr_i),
        .eret_i         (eret_i),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .int_pending_o  (int_pending_o),
        .flush_o        (flush_o),
        .flush_pc_o     (flush_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] flush_pc;
        logic        int_pend;
        logic        flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, kept as architectural fields.
    logic        m_ie, m_exl, m_bd, m_ti, m_pend, m_flush;
    logic [7:0]  m_im;
    logic [1:0]  m_sw;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badv, m_count, m_compare, m_fpc;
    int          m_ticks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_pend = 0; m_flush = 0;
        m_im = 0; m_sw = 0; m_code = 0;
        m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0; m_fpc = 0;
        m_ticks = 0;
    endtask

    function automatic logic [31:0] m_status();
        return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause(input logic [5:0] irq);
        return {m_bd, m_ti, 14'b0, irq[5] | m_ti, irq[4:0], m_sw, 1'b0, m_code, 2'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra, input logic [5:0] irq);
        case (ra)
            5'd8:    return m_badv;
            5'd9:    return TimerEn ? m_count : 32'h0;
            5'd11:   return TimerEn ? m_compare : 32'h0;
            5'd12:   return m_status();
            5'd13:   return m_cause(irq);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Apply one clock edge's worth of architectural rules to the model.
    task automatic model_edge(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [5:0] irq, input logic exc, input logic [4:0] code,
                              input logic [31:0] pc, input logic bd, input logic [31:0] bva,
                              input logic er);
        logic [7:0]  ip;
        logic        new_pend, cnt_w, cmp_w, match;
        ip       = {irq[5] | m_ti, irq[4:0], m_sw};
        new_pend = m_ie & !m_exl & ((m_im & ip) != 8'h0);
        match    = (m_count == m_compare);
        cnt_w    = 0;
        cmp_w    = 0;
        m_flush  = exc | er;
        if (exc) begin
            m_fpc = Vec;
            if (!m_exl) begin
                m_epc = bd ? pc - 32'd4 : pc;
                m_bd  = bd;
            end
            m_exl  = 1;
            m_code = code;
            if (code == 5'd4 || code == 5'd5) m_badv = bva;
        end else if (er) begin
            m_fpc = m_epc;
            m_exl = 0;
        end else if (we) begin
            if (wa == 5'd9) cnt_w = 1;
            if (wa == 5'd11) cmp_w = 1;
            if (wa == 5'd12) begin
                m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0];
            end
            if (wa == 5'd13) m_sw = wd[9:8];
            if (wa == 5'd14) m_epc = wd;
        end
        if (TimerEn) begin
            if (cnt_w) begin
                m_count = wd;
                m_ticks = 0;
            end else begin
                m_ticks = m_ticks + 1;
                if (m_ticks % CountDiv == 0) m_count = m_count + 32'd1;
            end
            if (cmp_w) m_compare = wd;
            if (cmp_w) m_ti = 0;
            else if (match) m_ti = 1;
        end
        m_pend = new_pend;
    endtask

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [5:0] irq, input logic exc,
                        input logic [4:0] code, input logic [31:0] pc, input logic bd,
                        input logic [31:0] bva, input logic er);
        exp_t e;
        we_i = we; waddr_i = wa; wdata_i = wd; raddr_i = ra; int_i = irq;
        exc_valid_i = exc; exc_code_i = code; exc_pc_i = pc; exc_bd_i = bd;
        exc_badvaddr_i = bva; eret_i = er;
        e.rdata    = m_read(ra, irq);
        e.status   = m_status();
        e.cause    = m_cause(irq);
        e.epc      = m_epc;
        e.flush_pc = m_fpc;
        e.int_pend = m_pend;
        e.flush    = m_flush;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(we, wa, wd, irq, exc, code, pc, bd, bva, er);
        #1;
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd, input logic [5:0] irq);
        step(1, wa, wd, wa, irq, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input logic [4:0] ra, input logic [5:0] irq);
        step(0, 0, 0, ra, irq, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic peek(input string name, input logic [4:0] ra, input logic [31:0] exp);
        raddr_i = ra;
        #1;
        check(name, rdata_o, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rdata", rdata_o, e.rdata);
                check("status", status_o, e.status);
                check("cause", cause_o, e.cause);
                check("epc", epc_o, e.epc);
                check("int_pending", 32'(int_pending_o), 32'(e.int_pend));
                check("flush", 32'(flush_o), 32'(e.flush));
                if (e.flush) check("flush_pc", flush_pc_o, e.flush_pc);
            end
        end
    end

    initial begin : stimulus
        logic [4:0] addr_pool [8];
        logic [5:0] irq;
        logic [4:0] wa, code;
        logic [31:0] wd;
        int r;
        bit found;
        addr_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_flush", 32'(flush_o), 32'h0);
        check("rst_int_pending", 32'(int_pending_o), 32'h0);
        rst = 1'b0;
        peek("rst_rd12", 5'd12, 32'h0040_0000);
        peek("rst_rd13", 5'd13, 32'h0);

        // Park Compare out of reach so TI stays quiet during directed checks.
        wr(5'd11, 32'hFFFF_FFFF, 6'h0);

        // Masked writes
        wr(5'd12, 32'hFFFF_FFFF, 6'h0);
        peek("status_mask", 5'd12, 32'h0040_FF03);
        wr(5'd8, 32'h0000_1234, 6'h0);
        peek("badvaddr_ro", 5'd8, 32'h0);
        wr(5'd12, 32'h0, 6'h0);

        // Delay-slot AdEL exception
        step(0, 0, 0, 5'd14, 6'h0, 1, 5'd4, 32'hBFC0_0104, 1, 32'h3, 0);
        check("exc_flush", 32'(flush_o), 32'h1);
        check("exc_flush_pc", flush_pc_o, 32'hBFC0_0380);
        peek("exc_epc", 5'd14, 32'hBFC0_0100);
        peek("exc_cause", 5'd13, 32'h8000_0010);
        peek("exc_badvaddr", 5'd8, 32'h3);
        peek("exc_status", 5'd12, 32'h0040_0002);
        step(0, 0, 0, 5'd14, 6'h0, 1, 5'd8, 32'h0000_0100, 0, 32'h0, 0);
        peek("nested_epc", 5'd14, 32'hBFC0_0100);
        peek("nested_cause", 5'd13, 32'h8000_0020);

        // eret returns to EPC sampled before the edge
        wr(5'd14, 32'hBFC0_0200, 6'h0);
        step(0, 0, 0, 5'd12, 6'h0, 0, 0, 0, 0, 0, 1);
        check("eret_flush", 32'(flush_o), 32'h1);
        check("eret_flush_pc", flush_pc_o, 32'hBFC0_0200);
        peek("eret_status", 5'd12, 32'h0040_0000);
        step(0, 0, 0, 5'd12, 6'h0, 1, 5'd12, 32'h0000_0040, 0, 32'h0, 1);
        check("exc_eret_flush_pc", flush_pc_o, Vec);
        peek("exc_eret_status", 5'd12, 32'h0040_0002);

`ifdef CP0_TIMER_EN
        wr(5'd11, 32'd10, 6'h0);
        wr(5'd9, 32'd0, 6'h0);
        wr(5'd12, 32'h0000_8001, 6'h0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle(5'd13, 6'h0);
            if (cause_o[30]) found = 1;
        end
        check("timer_ti_set", 32'(found), 32'h1);
        idle(5'd13, 6'h0);
        check("timer_int_pending", 32'(int_pending_o), 32'h1);
        wr(5'd11, 32'hFFFF_FFFF, 6'h0);
        check("timer_ti_clear", 32'(cause_o[30]), 32'h0);
        idle(5'd13, 6'h0);
        check("timer_int_clear", 32'(int_pending_o), 32'h0);
`endif

        // Hardware interrupt, then masked by EXL
        wr(5'd12, 32'h0000_0401, 6'h0);
        idle(5'd13, 6'h01);
        check("hw_int_pending", 32'(int_pending_o), 32'h1);
        wr(5'd12, 32'h0000_0403, 6'h01);
        idle(5'd13, 6'h01);
        check("hw_int_exl", 32'(int_pending_o), 32'h0);

        // Randomized traffic
        irq = 6'h0;
        for (int n = 0; n < 2000; n++) begin
            r = int'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) irq = 6'($urandom);
            wa = addr_pool[$urandom_range(0, 7)];
            wd = $urandom;
            if (wa == 5'd9 && $urandom_range(0, 1) == 1) wd = m_compare - $urandom_range(0, 8);
            code = ($urandom_range(0, 1) == 1) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
            step(r >= 12, wa, wd, addr_pool[$urandom_range(0, 7)], irq,
                 r < 2 || r == 3, code, $urandom, 1'($urandom), $urandom, r >= 2 && r < 4);
        end

        // Asynchronous reset mid-flush
        step(0, 0, 0, 5'd12, irq, 1, 5'd0, 32'h0000_1000, 0, 32'h0, 0);
        check("pre_rst_flush", 32'(flush_o), 32'h1);
        exc_valid_i = 1'b0;
        int_i = 6'h0;
        rst = 1'b1;
        #1;
        check("midrst_flush", 32'(flush_o), 32'h0);
        check("midrst_status", status_o, 32'h0040_0000);
        check("midrst_epc", epc_o, 32'h0);
        check("midrst_int_pending", 32'(int_pending_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(5'd13, 6'h0);
        idle(5'd12, 6'h0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
